// File: rtl/isqrt_pipe_nr.sv
// Fully pipelined floor(sqrt(x)) using restoring digit-by-digit extraction, one root bit per stage.
// Define ISQRT_PIPE_VLD_GATE_EN to load data registers only behind a valid (power-saving build).
module isqrt_pipe_nr #(
   parameter int N = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_vld,
   input  logic [N-1:0]     x,
   output logic             y_vld,
   output logic [N/2-1:0]   y
);

   localparam int H = N / 2;
   localparam int R = H + 2;
   localparam int S = H;

`ifdef ISQRT_PIPE_VLD_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   logic [S-1:0] r_vld;
   logic [R-1:0] r_rem  [S];
   logic [H-1:0] r_root [S];
   logic [N-1:0] r_op   [S];

   logic [S-1:0] w_ld;
   logic [R-1:0] w_rem_in   [S];
   logic [H-1:0] w_root_in  [S];
   logic [N-1:0] w_op_in    [S];
   logic [R-1:0] w_rem_sh   [S];
   logic [R-1:0] w_trial    [S];
   logic [S-1:0] w_fit;
   logic [R-1:0] w_rem_nxt  [S];
   logic [H-1:0] w_root_nxt [S];

   assign w_ld = {r_vld[S-2:0], x_vld};

   for (genvar g = 0; g < S; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign w_rem_in[g]  = '0;
         assign w_root_in[g] = '0;
         assign w_op_in[g]   = x;
      end else begin : g_next
         assign w_rem_in[g]  = r_rem[g-1];
         assign w_root_in[g] = r_root[g-1];
         assign w_op_in[g]   = r_op[g-1];
      end

      // The incoming remainder never exceeds R-2 bits, so dropping its top two bits is lossless.
      assign w_rem_sh[g]   = {w_rem_in[g][R-3:0], w_op_in[g][N-1:N-2]};
      assign w_trial[g]    = {w_root_in[g], 2'b01};
      assign w_fit[g]      = (w_rem_sh[g] >= w_trial[g]);
      assign w_rem_nxt[g]  = w_fit[g] ? (w_rem_sh[g] - w_trial[g]) : w_rem_sh[g];
      assign w_root_nxt[g] = {w_root_in[g][H-2:0], w_fit[g]};
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         r_vld <= w_ld;
      end
   end

   // NOTE: datapath registers carry no reset; the valid bits alone decide what is meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < S; i++) begin
         if (!GATE || w_ld[i]) begin
            r_rem[i]  <= w_rem_nxt[i];
            r_root[i] <= w_root_nxt[i];
            r_op[i]   <= {w_op_in[i][N-3:0], 2'b00};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_vld <= 1'b0;
         y     <= '0;
      end else begin
         y_vld <= r_vld[S-1];
         if (!GATE || r_vld[S-1]) begin
            y <= r_root[S-1];
         end
      end
   end

endmodule

// File: tb/tb_isqrt_pipe_nr.sv
// Self-checking bench for isqrt_pipe_nr (N=32): directed corners plus random streams vs a floor-sqrt model.
module tb_isqrt_pipe_nr;

   localparam int N = 32;
   localparam int S = N / 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          x_vld;
   logic [N-1:0]  x;
   logic          y_vld;
   logic [S-1:0]  y;

   int checks   = 0;
   int failures = 0;
   int n_out    = 0;
   logic [S-1:0] last_y;

   typedef struct {
      bit           vld;
      logic [S-1:0] y;
   } exp_t;

   exp_t q[$];

   isqrt_pipe_nr #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld),
      .y     (y)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [S-1:0] ref_isqrt(input logic [N-1:0] v);
      longint r;
      longint lv;
      lv = longint'({32'd0, v});
      r  = longint'($floor($sqrt(real'(lv))));
      while (r * r > lv) r--;
      while ((r + 1) * (r + 1) <= lv) r++;
      return r[S-1:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      exp_t e;
      e.vld = 1'b0;
      e.y   = '0;
      q.delete();
      for (int i = 0; i < S; i++) q.push_back(e);
      last_y = '0;
   endtask

   // Drive one cycle, then compare the output against the operand sampled S edges earlier.
   task automatic cycle(input logic vld, input logic [N-1:0] xv);
      exp_t e;
      x_vld = vld;
      x     = xv;
      e.vld = vld;
      e.y   = ref_isqrt(xv);
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      if (y_vld) n_out++;
      check("y_vld", 32'(y_vld), 32'(e.vld));
      if (e.vld) begin
         check("y", 32'(y), 32'(e.y));
         last_y = e.y;
      end
`ifdef ISQRT_PIPE_VLD_GATE_EN
      else check("y_hold", 32'(y), 32'(last_y));
`endif
   endtask

   logic [N-1:0] corners [7];
   logic [N-1:0] extremes [4];

   initial begin
      corners  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'd16};
      extremes = '{32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000, 32'h4000_0000};

      rst   = 1'b1;
      x_vld = 1'b0;
      x     = '0;
      #1;
      check("reset_y_vld", 32'(y_vld), 32'd0);
      check("reset_y", 32'(y), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      reset_model();

      // Corner values back-to-back, then extremes, then drain.
      foreach (corners[i]) cycle(1'b1, corners[i]);
      foreach (extremes[i]) cycle(1'b1, extremes[i]);
      repeat (S + 2) cycle(1'b0, $urandom);
      check("ref_extreme", 32'(ref_isqrt(32'hFFFE_0000)), 32'hFFFE);

      // Streaming with x_vld held high.
      n_out = 0;
      repeat (10000) cycle(1'b1, $urandom);
      repeat (S) cycle(1'b0, $urandom);
      check("stream_count", 32'(n_out), 32'd10000);

      // Random bubbles, ~50% density.
      repeat (2000) cycle(1'($urandom_range(0, 1)), $urandom);
      repeat (S) cycle(1'b0, $urandom);

      // Async reset with 8 operands in flight and one result on the output.
      cycle(1'b1, $urandom);
      repeat (8) cycle(1'b0, $urandom);
      repeat (8) cycle(1'b1, $urandom | 32'h0100_0000);
      check("pre_reset_y_vld", 32'(y_vld), 32'd1);
      x_vld = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("async_rst_y_vld", 32'(y_vld), 32'd0);
      check("async_rst_y", 32'(y), 32'd0);
      @(posedge clk);
      #1;
      check("held_rst_y_vld", 32'(y_vld), 32'd0);
      check("held_rst_y", 32'(y), 32'd0);
      #3 rst = 1'b0;
      reset_model();
      repeat (40) cycle(1'b0, $urandom);
      cycle(1'b1, 32'd81);
      repeat (S) cycle(1'b0, $urandom);
      check("post_reset_81", 32'(last_y), 32'd9);

      // Gating: a single operand, then idle cycles with a toggling x.
      cycle(1'b1, 32'd144);
      repeat (40 + S) cycle(1'b0, $urandom);
`ifdef ISQRT_PIPE_VLD_GATE_EN
      check("gate_hold_12", 32'(y), 32'd12);
`endif
      check("gate_last_12", 32'(last_y), 32'd12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
